// File: rtl/pipe_comparator.sv
// pipe_comparator: two-stage pipelined magnitude comparator with valid/ready
// handshaking on both sides and per-transaction signed/unsigned mode.
//
//   Stage 1 splits the operands into SEG_WIDTH-bit segments and registers a
//   per-segment greater/equal pair. Stage 2 merges the segments MSB-first and
//   registers the one-hot result flags together with outValid.
//
// Parameters:
//   WIDTH       operand width (>= 2)
//   SEG_WIDTH   stage-1 segment width (WIDTH must be a multiple of it)
//   COUNT_WIDTH width of the optional result counters
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   inValid / inReady       input handshake for (a, b, signedMode)
//   a, b                    operands
//   signedMode              1 = two's-complement compare, 0 = unsigned
//   outValid / outReady     output handshake
//   aGreaterB/aEqualB/aLessB one-hot result flags, qualified by outValid
//   statClear               synchronous clear of the result counters
//   cntGreater/Equal/Less   saturating result counters
//
// Optional feature: define PIPE_COMPARATOR_STATS_EN to build the result
// counters. Without it the counter outputs are tied to zero and statClear
// is ignored.

module pipe_comparator #(
    parameter int WIDTH       = 8,
    parameter int SEG_WIDTH   = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic                   signedMode,
    output logic                   outValid,
    input  logic                   outReady,
    output logic                   aGreaterB,
    output logic                   aEqualB,
    output logic                   aLessB,
    input  logic                   statClear,
    output logic [COUNT_WIDTH-1:0] cntGreater,
    output logic [COUNT_WIDTH-1:0] cntEqual,
    output logic [COUNT_WIDTH-1:0] cntLess
);

    localparam int unsigned NSEG = WIDTH / SEG_WIDTH;

    if (WIDTH < 2) begin : g_bad_width
        $error("pipe_comparator: WIDTH must be at least 2");
    end
    if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_seg
        $error("pipe_comparator: WIDTH must be a multiple of SEG_WIDTH");
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic advance1;
    logic advance2;
    logic s1_valid;

    assign advance2 = !outValid || outReady;
    assign advance1 = !s1_valid || advance2;
    assign inReady  = advance1;

    // ------------------------------------------------------------------
    // Stage 1: per-segment compare
    // ------------------------------------------------------------------
    logic [NSEG-1:0]      seg_gt;
    logic [NSEG-1:0]      seg_eq;
    logic                 seg_gt_msb_signed;
    logic [SEG_WIDTH-1:0] sign_mask;

    always_comb begin
        seg_gt    = '0;
        seg_eq    = '0;
        sign_mask = '0;
        sign_mask[SEG_WIDTH-1] = 1'b1;
        for (int unsigned i = 0; i < NSEG; i++) begin
            seg_gt[i] = a[i*SEG_WIDTH +: SEG_WIDTH] > b[i*SEG_WIDTH +: SEG_WIDTH];
            seg_eq[i] = a[i*SEG_WIDTH +: SEG_WIDTH] == b[i*SEG_WIDTH +: SEG_WIDTH];
        end
        // Inverting the sign bits turns the unsigned MSB-segment compare
        // into a two's-complement one.
        seg_gt_msb_signed = (a[WIDTH-1 -: SEG_WIDTH] ^ sign_mask) >
                            (b[WIDTH-1 -: SEG_WIDTH] ^ sign_mask);
    end

    logic [NSEG-1:0] s1_gt;
    logic [NSEG-1:0] s1_eq;
    logic            s1_gt_msb_signed;
    logic            s1_signed;

    // The MSB segment keeps both its unsigned and signed greater bit; the
    // registered mode selects between them in stage 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid         <= 1'b0;
            s1_gt            <= '0;
            s1_eq            <= '0;
            s1_gt_msb_signed <= 1'b0;
            s1_signed        <= 1'b0;
        end else if (advance1) begin
            s1_valid <= inValid;
            if (inValid) begin
                s1_gt            <= seg_gt;
                s1_eq            <= seg_eq;
                s1_gt_msb_signed <= seg_gt_msb_signed;
                s1_signed        <= signedMode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: MSB-first priority merge
    // ------------------------------------------------------------------
    logic merged_gt;
    logic merged_eq;

    // Walking upward lets the highest unequal segment overwrite lower ones.
    always_comb begin
        merged_gt = 1'b0;
        merged_eq = &s1_eq;
        for (int unsigned i = 0; i < NSEG; i++) begin
            if (!s1_eq[i]) begin
                if (i == NSEG - 1 && s1_signed) begin
                    merged_gt = s1_gt_msb_signed;
                end else begin
                    merged_gt = s1_gt[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid  <= 1'b0;
            aGreaterB <= 1'b0;
            aEqualB   <= 1'b0;
            aLessB    <= 1'b0;
        end else if (advance2) begin
            outValid <= s1_valid;
            // Flags only change when a new result lands; otherwise they
            // keep their last value.
            if (s1_valid) begin
                aGreaterB <= merged_gt;
                aEqualB   <= merged_eq;
                aLessB    <= !merged_gt && !merged_eq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional result counters
    // ------------------------------------------------------------------
`ifdef PIPE_COMPARATOR_STATS_EN
    logic out_xfer;
    assign out_xfer = outValid && outReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntGreater <= '0;
            cntEqual   <= '0;
            cntLess    <= '0;
        end else if (statClear) begin
            cntGreater <= '0;
            cntEqual   <= '0;
            cntLess    <= '0;
        end else if (out_xfer) begin
            if (aGreaterB && cntGreater != '1) cntGreater <= cntGreater + 1'b1;
            if (aEqualB   && cntEqual   != '1) cntEqual   <= cntEqual + 1'b1;
            if (aLessB    && cntLess    != '1) cntLess    <= cntLess + 1'b1;
        end
    end
`else
    logic unused_stat_clear;
    assign unused_stat_clear = statClear;
    assign cntGreater = '0;
    assign cntEqual   = '0;
    assign cntLess    = '0;
`endif

endmodule

// File: tb/tb_pipe_comparator.sv
// tb_pipe_comparator: directed self-checking bench for pipe_comparator.
// Three instances share the handshake signals: an 8-bit one with 4-bit
// segments, an 8-bit single-segment one, and a 16-bit one with 4-bit
// segments. Expected flags are hand-computed per vector.

module tb_pipe_comparator;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] L = 3'b001;
    localparam int CW = 2;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        outReady;
    logic        signedMode;
    logic        statClear;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic          rdy8, rdy8s, rdy16;
    logic          ov8, ov8s, ov16;
    logic [2:0]    f8, f8s, f16;
    logic [CW-1:0] cg8, ce8, cl8;
    logic [CW-1:0] cg8s, ce8s, cl8s;
    logic [CW-1:0] cg16, ce16, cl16;

    pipe_comparator #(.WIDTH(8), .SEG_WIDTH(4), .COUNT_WIDTH(CW)) u_dut8 (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(rdy8),
        .a(a8), .b(b8), .signedMode(signedMode),
        .outValid(ov8), .outReady(outReady),
        .aGreaterB(f8[2]), .aEqualB(f8[1]), .aLessB(f8[0]),
        .statClear(statClear),
        .cntGreater(cg8), .cntEqual(ce8), .cntLess(cl8)
    );

    pipe_comparator #(.WIDTH(8), .SEG_WIDTH(8), .COUNT_WIDTH(CW)) u_dut8s (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(rdy8s),
        .a(a8), .b(b8), .signedMode(signedMode),
        .outValid(ov8s), .outReady(outReady),
        .aGreaterB(f8s[2]), .aEqualB(f8s[1]), .aLessB(f8s[0]),
        .statClear(statClear),
        .cntGreater(cg8s), .cntEqual(ce8s), .cntLess(cl8s)
    );

    pipe_comparator #(.WIDTH(16), .SEG_WIDTH(4), .COUNT_WIDTH(CW)) u_dut16 (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(rdy16),
        .a(a16), .b(b16), .signedMode(signedMode),
        .outValid(ov16), .outReady(outReady),
        .aGreaterB(f16[2]), .aEqualB(f16[1]), .aLessB(f16[0]),
        .statClear(statClear),
        .cntGreater(cg16), .cntEqual(ce16), .cntLess(cl16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected results in input order: {flags8, flags16}.
    logic [5:0] q[$];
    logic [5:0] popped;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_f8 = '0;

    // Output monitor: samples on the falling edge, scoring each transfer
    // that the next rising edge will perform.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, ov8}, 32'd1);
                check("stall_flags", {29'd0, f8}, {29'd0, prev_f8});
            end
            if (ov8) check("onehot8", $countones(f8), 32'd1);
            if (ov8 && outReady) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    popped = q.pop_front();
                    check("res8", {29'd0, f8}, {29'd0, popped[5:3]});
                    check("res8_seg", {29'd0, f8s}, {29'd0, popped[5:3]});
                    check("res16", {29'd0, f16}, {29'd0, popped[2:0]});
                    check("valid8_seg", {31'd0, ov8s}, 32'd1);
                    check("valid16", {31'd0, ov16}, 32'd1);
                end
            end
            prev_stall <= ov8 && !outReady;
            prev_f8    <= f8;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the pair transfers.
    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic sm,
                        input logic [2:0] e8, input logic [15:0] ya,
                        input logic [15:0] yb, input logic [2:0] e16);
        int n;
        n = 0;
        a8 = xa; b8 = xb; a16 = ya; b16 = yb; signedMode = sm; inValid = 1'b1;
        #1;
        while (!rdy8 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (!rdy8) check("in_timeout", 32'd0, 32'd1);
        else q.push_back({e8, e16});
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] xa, input logic [7:0] xb, input logic sm,
                         input logic [2:0] e8);
        send(xa, xb, sm, e8, 16'h0000, 16'h0000, E);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1; signedMode = 1'b0;
        statClear = 1'b0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, ov8}, 32'd0);
        check("rst_flags", {29'd0, f8}, 32'd0);
        check("rst_cnt", {26'd0, cg8, ce8, cl8}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, rdy8}, 32'd1);
        @(posedge clk); #1;

        // Latency: three pairs back to back, results on cycles 2..4
        a8 = 8'h05; b8 = 8'h03; signedMode = 1'b0; inValid = 1'b1;
        check("lat_ready0", {31'd0, rdy8}, 32'd1);
        q.push_back({G, E});
        @(posedge clk); #1;
        a8 = 8'h03; b8 = 8'h03;
        check("lat_ready1", {31'd0, rdy8}, 32'd1);
        q.push_back({E, E});
        @(posedge clk); #1;
        check("lat_c2_valid", {31'd0, ov8}, 32'd1);
        check("lat_c2_flags", {29'd0, f8}, {29'd0, G});
        a8 = 8'h02; b8 = 8'h09;
        q.push_back({L, E});
        @(posedge clk); #1;
        inValid = 1'b0;
        check("lat_c3_valid", {31'd0, ov8}, 32'd1);
        check("lat_c3_flags", {29'd0, f8}, {29'd0, E});
        @(posedge clk); #1;
        check("lat_c4_valid", {31'd0, ov8}, 32'd1);
        check("lat_c4_flags", {29'd0, f8}, {29'd0, L});
        @(posedge clk); #1;
        check("lat_c5_idle", {31'd0, ov8}, 32'd0);

        // Signed / unsigned boundaries and equal extremes
        send8(8'h80, 8'h7F, 1'b1, L);
        send8(8'hFF, 8'hFE, 1'b1, G);
        send8(8'h80, 8'h7F, 1'b0, G);
        send8(8'hFF, 8'hFE, 1'b0, G);
        send8(8'h00, 8'h00, 1'b1, E);
        send8(8'hFF, 8'hFF, 1'b1, E);
        send8(8'hFF, 8'hFF, 1'b0, E);
        send8(8'h01, 8'hFF, 1'b1, G);
        drain();

        // Segment boundaries on the 16-bit instance
        send(8'h00, 8'h00, 1'b0, E, 16'h1200, 16'h11FF, G);
        send(8'h00, 8'h00, 1'b0, E, 16'hABCD, 16'hABCE, L);
        send(8'h00, 8'h00, 1'b0, E, 16'hFFFF, 16'hFFFF, E);
        send(8'h00, 8'h00, 1'b1, E, 16'h8000, 16'h7FFF, L);
        send(8'h00, 8'h00, 1'b0, E, 16'h8000, 16'h7FFF, G);
        drain();

        // Backpressure: outReady low for four edges in the middle of a stream
        fork
            begin
                send8(8'h10, 8'h20, 1'b0, L);
                send8(8'h20, 8'h10, 1'b0, G);
                send8(8'h33, 8'h33, 1'b0, E);
                send8(8'hFF, 8'h00, 1'b0, G);
                send8(8'hFF, 8'h01, 1'b1, L);
                send8(8'h7F, 8'h80, 1'b0, L);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                outReady = 1'b0;
                @(posedge clk); #2;
                check("bp_ready_low", {31'd0, rdy8}, 32'd0);
                check("bp_valid_held", {31'd0, ov8}, 32'd1);
                repeat (3) @(posedge clk);
                #1;
                outReady = 1'b1;
            end
        join
        drain();

`ifdef PIPE_COMPARATOR_STATS_EN
        // Counters: saturation and clear priority
        statClear = 1'b1;
        @(posedge clk); #1;
        statClear = 1'b0;
        check("st_clr", {26'd0, cg8, ce8, cl8}, 32'd0);
        repeat (5) send8(8'h03, 8'h03, 1'b0, E);
        drain();
        check("st_eq_sat", {30'd0, ce8}, 32'd3);
        check("st_gt_zero", {30'd0, cg8}, 32'd0);
        check("st_lt_zero", {30'd0, cl8}, 32'd0);
        a8 = 8'h03; b8 = 8'h03; signedMode = 1'b0; inValid = 1'b1;
        q.push_back({E, E});
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        check("st_6th_valid", {31'd0, ov8}, 32'd1);
        statClear = 1'b1;
        @(posedge clk); #1;
        statClear = 1'b0;
        check("st_clr_prio", {30'd0, ce8}, 32'd0);
        send8(8'h05, 8'h03, 1'b0, G);
        drain();
        check("st_gt_one", {30'd0, cg8}, 32'd1);
`else
        statClear = 1'b1;
        send8(8'h05, 8'h03, 1'b0, G);
        drain();
        statClear = 1'b0;
        check("cnt_tied", {26'd0, cg8, ce8, cl8}, 32'd0);
`endif

        // Reset mid-operation: two pairs in flight, then reset
        a8 = 8'h01; b8 = 8'h02; signedMode = 1'b0; inValid = 1'b1;
        @(posedge clk); #1;
        a8 = 8'h03;
        @(posedge clk); #1;
        inValid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, ov8}, 32'd0);
        check("mid_rst_flags", {29'd0, f8}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, rdy8}, 32'd1);
        check("mid_rst_cnt", {26'd0, cg8, ce8, cl8}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mid_rst_quiet", {31'd0, ov8}, 32'd0);
        end
        check("mid_rst_queue", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_comparator.md
Name: pipe_comparator

Overview:
- Pipelined, parametrised magnitude comparator; successor to the single-cycle combinational 8-bit comparator.
- Accepts operand pairs on a valid/ready stream and returns one-hot greater/equal/less flags two cycles later, with backpressure.
- Supports per-transaction signed/unsigned mode and a segmented first stage so wide operands meet timing.
- Sits between sample producers (ALU / filter taps) and downstream control logic.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- SEG_WIDTH, 4, stage-1 segment width; WIDTH must be a multiple of SEG_WIDTH.
- COUNT_WIDTH, 16, statistics counter width; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- inValid  input  1  operand pair valid
- inReady  output  1  block can accept a pair this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- signedMode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b
- outValid  output  1  result valid
- outReady  input  1  consumer accepts result
- aGreaterB  output  1  A > B
- aEqualB  output  1  A == B
- aLessB  output  1  A < B
- statClear  input  1  synchronous counter clear (optional feature only)
- cntGreater, cntEqual, cntLess  output  COUNT_WIDTH each  result counters (optional feature only)

Behaviour:
- Reset (async, active-high), all registers cleared:
  - outValid=0, aGreaterB=aEqualB=aLessB=0, stage valids=0, counters=0.
  - inReady=1 once reset deasserts.
- Transfers:
  - Input transfer when inValid && inReady.
  - Output transfer when outValid && outReady.
- Stage 1 (S1): registers signedMode plus, per segment i, gt_i (seg A > seg B, unsigned) and eq_i (seg A == seg B).
  - Signed mode: for the MSB segment only, gt is computed with the sign bits inverted, i.e. a signed compare.
- Stage 2 (S2): MSB-first priority merge.
  - aGreaterB = gt of the highest unequal segment; aEqualB = AND of all eq_i; aLessB = !aGreaterB && !aEqualB.
  - Registered into the output flags with outValid.
- Latency: exactly 2 cycles from input transfer to outValid when outReady=1. Throughput: 1 pair/cycle.
- Stall rules:
  - advance2 = !outValid || outReady
  - advance1 = !s1Valid || advance2
  - inReady = advance1 (combinational; no combinational path from inValid to inReady)
- Output stability: while outValid=1 and outReady=0, flags hold stable.
- Flag encoding:
  - Exactly one flag is high whenever outValid=1.
  - When outValid=0, flags keep their last value; consumers must qualify with outValid.
- Ordering: results emerge in input order; no drops or duplicates under any outReady pattern.
- Boundaries:
  - Equal extremes compare equal in both modes (all-zero, all-one).
  - Signed mode: 0x80 < 0x7F. Unsigned mode: 0x80 > 0x7F.
  - SEG_WIDTH == WIDTH degenerates to a single-segment compare; results are identical.
- Reset mid-operation: in-flight pairs are discarded, no result is emitted afterwards, counters clear.

Optional Feature:
- Macro: PIPE_COMPARATOR_STATS_EN.
- Defined:
  - cntGreater/cntEqual/cntLess each increment by 1 on an output transfer with the matching flag.
  - Counters saturate at all-ones; no wrap.
  - statClear=1 zeroes all three at the next edge and takes priority over a same-cycle increment.
- Undefined: the counter registers are not built; count outputs are tied to 0 and statClear is ignored.

Test Plan:
- WIDTH=8, outReady=1, unsigned: (a,b) = (0x05,0x03), (0x03,0x03), (0x02,0x09) on consecutive cycles -> cycles 2, 3, 4 show G, E, L respectively, with outValid high each cycle.
- signedMode=1: (0x80,0x7F) -> L; (0xFF,0xFE) -> G. signedMode=0 with the same pairs -> G, G.
- Backpressure: stream 6 pairs, hold outReady=0 for cycles 3–6 -> inReady drops by cycle 4, flags stay stable during the stall, all 6 results arrive in order after release.
- Segment boundary, WIDTH=16, SEG_WIDTH=4: (0x1200,0x11FF) -> G; (0xABCD,0xABCE) -> L; (0xFFFF,0xFFFF) -> E.
- Reset asserted the cycle after 2 input transfers -> outValid stays 0 after reset, inReady=1, no stale result appears.
- STATS_EN, COUNT_WIDTH=2: 5 equal results -> cntEqual=3 (saturated); statClear together with a 6th equal result -> cntEqual=0.
